// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
// FSM encodings, word constants and the address range/alignment check.
package dmem_responder_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // An access is bad when it is not word aligned or its word offset
    // from base does not fit in a 2**addr_w word window. An address
    // below base wraps to a huge offset and is flagged too.
    function automatic logic addr_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned addr_w
    );
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || ((off >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte write enables.
// Synchronous read, no reset on the array or the read register.
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Enabled access: lane-masked write plus read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, wait states, one-cycle
// response pulse, backed by dmem_ram.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0]  WAIT_INIT = WAIT_M1[3:0];

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic              go_resp;

    logic              lat_we;
    logic              lat_err;
    logic [BE_W-1:0]   lat_be;
    logic [ADDR_W-1:0] lat_idx;
    logic [WORD_W-1:0] lat_wdata;

    logic              in_idle;
    logic              accept;
    logic              req_err;
    logic [31:0]       req_off;
    logic [ADDR_W-1:0] req_idx;

    logic              ram_en;
    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0] ram_idx;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    assign in_idle = (state == ST_IDLE);
    assign accept  = req_valid && in_idle;
    assign req_err = addr_err(req_addr, BASE_ADDR, ADDR_W);
    assign req_off = req_addr - BASE_ADDR;
    assign req_idx = req_off[ADDR_W+1:2];

    // Next state and wait counter; go_resp marks the edge entering RESP.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        go_resp  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = WAIT_INIT;
                    end else begin
                        state_nx = ST_RESP;
                        go_resp  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = ST_RESP;
                    go_resp  = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Capture the request on the accept edge; inputs are ignored after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_be    <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_err   <= req_err;
            lat_be    <= req_be;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
        end
    end

    // With zero wait states the RAM access shares the accept edge, so
    // the live request drives the RAM while idle. Reset blocks the commit.
    always_comb begin
        ram_idx   = lat_idx;
        ram_be    = lat_be;
        ram_wdata = lat_wdata;
        ram_we    = lat_we && !lat_err;
        if (in_idle) begin
            ram_idx   = req_idx;
            ram_be    = req_be;
            ram_wdata = req_wdata;
            ram_we    = req_we && !req_err;
        end
        ram_en = go_resp && !rst;
        ram_we = ram_we && ram_en;
    end

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready = in_idle;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid && lat_err;
    assign rsp_rdata = (rsp_valid && !lat_err && !lat_we) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at 0, 1 and 3 wait states.
// Instance 0: WAIT=0, instance 1: WAIT=1, instance 2: WAIT=3.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [3:0]  req_be    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata [3];
    logic [2:0]  rsp_err;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_be(req_be[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_w1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_be(req_be[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_w3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_be(req_be[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2])
    );

    // One transaction on instance i. lat is the cycle count from the
    // accept edge to the response (1 = right after the accept edge),
    // -1 on timeout. pulse_ok: the cycle after the pulse is all zero.
    task automatic do_req(
        input  int          i,
        input  logic        we,
        input  logic [3:0]  be,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output logic [31:0] rdata,
        output logic        err,
        output int          lat,
        output bit          pulse_ok
    );
        bit acc;
        bit got;
        acc = 0;
        got = 0;
        lat = -1;
        rdata = '0;
        err = 1'b0;
        pulse_ok = 0;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_be[i]    = be;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        for (int c = 0; c < 20 && !acc; c++) begin
            acc = req_ready[i];
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        #1;
        req_valid[i] = 1'b0;
        req_we[i]    = ~we;
        req_be[i]    = ~be;
        req_addr[i]  = 32'hFFFF_FFFF;
        req_wdata[i] = ~wdata;
        if (acc) begin
            for (int c = 1; c <= 30 && !got; c++) begin
                if (rsp_valid[i]) begin
                    got   = 1;
                    lat   = c;
                    rdata = rsp_rdata[i];
                    err   = rsp_err[i];
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (got) begin
                @(posedge clk);
                #1;
                pulse_ok = !rsp_valid[i] && !rsp_err[i] &&
                           (rsp_rdata[i] == 32'h0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready[1]);
        end
        checks++;
        if (rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", rsp_valid[1]);
        end
        checks++;
        if (rsp_rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", rsp_rdata[1]);
        end
        checks++;
        if (rsp_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", rsp_err[1]);
        end
        rst = 1'b0;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_be[1]    = 4'hF;
        req_addr[1]  = 32'h13;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid[1], rsp_err[1]} !== 2'b11) begin
            errors++;
            $display("FAIL async_pre got v/e %b%b want 11",
                     rsp_valid[1], rsp_err[1]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]} !==
            {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL async_clear got r/v/e %b%b%b d %h want 100 d 0",
                     req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] d;
        logic        e;
        int          l;
        bit          p;
        do_req(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, d, e, l, p);
        checks++;
        if (l != 2 || e !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL store_ack got lat %0d err %b d %h want 2 0 0", l, e, d);
        end
        checks++;
        if (!p) begin
            errors++;
            $display("FAIL store_pulse got extra cycle want single pulse");
        end
        do_req(1, 1'b0, 4'h0, 32'h10, 32'h0, d, e, l, p);
        checks++;
        if (l != 2 || e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_word got lat %0d err %b d %h want 2 0 deadbeef",
                     l, e, d);
        end
        checks++;
        if (!p) begin
            errors++;
            $display("FAIL load_pulse got extra cycle want single pulse");
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d;
        logic        e;
        int          l;
        bit          p;
        do_req(1, 1'b1, 4'b0100, 32'h10, 32'h00AA_0000, d, e, l, p);
        do_req(1, 1'b0, 4'hF, 32'h10, 32'h0, d, e, l, p);
        checks++;
        if (d !== 32'hDEAA_BEEF) begin
            errors++;
            $display("FAIL be_lane2 got %h want deaabeef", d);
        end
        do_req(1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, d, e, l, p);
        checks++;
        if (l != 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL be_none_ack got lat %0d err %b want 2 0", l, e);
        end
        do_req(1, 1'b0, 4'h0, 32'h10, 32'h0, d, e, l, p);
        checks++;
        if (d !== 32'hDEAA_BEEF) begin
            errors++;
            $display("FAIL be_none_data got %h want deaabeef", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        e;
        int          l;
        bit          p;
        do_req(1, 1'b0, 4'hF, 32'h13, 32'h0, d, e, l, p);
        checks++;
        if (l != 2 || e !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL err_misalign got lat %0d err %b d %h want 2 1 0",
                     l, e, d);
        end
        do_req(1, 1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, d, e, l, p);
        do_req(1, 1'b1, 4'hF, 32'h1000, 32'h5555_5555, d, e, l, p);
        checks++;
        if (l != 2 || e !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL err_range got lat %0d err %b d %h want 2 1 0",
                     l, e, d);
        end
        do_req(1, 1'b0, 4'hF, 32'h0, 32'h0, d, e, l, p);
        checks++;
        if (e !== 1'b0 || d !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL err_range_word0 got err %b d %h want 0 0badf00d", e, d);
        end
        do_req(1, 1'b1, 4'hF, 32'h12, 32'h1111_1111, d, e, l, p);
        do_req(1, 1'b0, 4'hF, 32'h10, 32'h0, d, e, l, p);
        checks++;
        if (e !== 1'b0 || d !== 32'hDEAA_BEEF) begin
            errors++;
            $display("FAIL err_misalign_store got err %b d %h want 0 deaabeef",
                     e, d);
        end
    endtask

    // Four loads with valid held high; checks accept spacing, stall
    // cycles seen by the requester, and in-order response data.
    task automatic test_stream(input int i, input int w);
        logic [31:0] d;
        logic        e;
        int          l;
        bit          p;
        int          edge_n;
        int          na;
        int          nr;
        int          stalls;
        int          acc_edge [4];
        logic [31:0] got [4];
        logic [31:0] exp_d;
        bit          take;
        for (int k = 0; k < 4; k++) begin
            exp_d = 32'hA000_0000 + k * 32'h0101_0101;
            do_req(i, 1'b1, 4'hF, 32'h40 + 4 * k, exp_d, d, e, l, p);
        end
        edge_n = 0;
        na = 0;
        nr = 0;
        stalls = 0;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_we[i]    = 1'b0;
        req_be[i]    = 4'hF;
        req_addr[i]  = 32'h40;
        for (int c = 0; c < 80 && nr < 4; c++) begin
            take = req_valid[i] && req_ready[i];
            if (req_valid[i] && !req_ready[i]) stalls++;
            @(posedge clk);
            edge_n++;
            if (take) begin
                acc_edge[na] = edge_n;
                na++;
            end
            #1;
            if (take) begin
                if (na < 4) req_addr[i] = 32'h40 + 4 * na;
                else req_valid[i] = 1'b0;
            end
            if (rsp_valid[i]) begin
                got[nr] = rsp_rdata[i];
                nr++;
            end
            @(negedge clk);
        end
        req_valid[i] = 1'b0;
        checks++;
        if (na != 4 || nr != 4) begin
            errors++;
            $display("FAIL stream_w%0d_count got acc %0d rsp %0d want 4 4",
                     w, na, nr);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (acc_edge[k+1] - acc_edge[k] != w + 2) begin
                    errors++;
                    $display("FAIL stream_w%0d_gap%0d got %0d want %0d",
                             w, k, acc_edge[k+1] - acc_edge[k], w + 2);
                end
            end
            for (int k = 0; k < 4; k++) begin
                exp_d = 32'hA000_0000 + k * 32'h0101_0101;
                checks++;
                if (got[k] !== exp_d) begin
                    errors++;
                    $display("FAIL stream_w%0d_rsp%0d got %h want %h",
                             w, k, got[k], exp_d);
                end
            end
        end
        checks++;
        if (stalls != 3 * (w + 1)) begin
            errors++;
            $display("FAIL stream_w%0d_stalls got %0d want %0d",
                     w, stalls, 3 * (w + 1));
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d;
        logic        e;
        int          l;
        bit          p;
        bit          seen;
        do_req(1, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, d, e, l, p);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_be[1]    = 4'hF;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        checks++;
        if (req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL wait_ready got %b want 0", req_ready[1]);
        end
        #2;
        rst = 1'b1;
        seen = 0;
        @(posedge clk);
        #1;
        if (rsp_valid[1]) seen = 1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid[1]) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL wait_rst_rsp got pulse want none");
        end
        do_req(1, 1'b0, 4'hF, 32'h20, 32'h0, d, e, l, p);
        checks++;
        if (e !== 1'b0 || d !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL wait_rst_data got err %b d %h want 0 cafef00d", e, d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req_valid = '0;
        req_we = '0;
        for (int i = 0; i < 3; i++) begin
            req_be[i]    = 4'h0;
            req_addr[i]  = 32'h0;
            req_wdata[i] = 32'h0;
        end
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_stream(0, 0);
        test_stream(2, 3);
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
